// File: rtl/linear_cordic_pkg.sv
// -----------------------------------------------------------------------------
// linear_cordic_pkg
// Shared definitions for the linear CORDIC blocks: default datapath geometry
// (Q3.23 in a 27-bit word, 24 rotation steps), the controller state encoding
// and a helper that sizes the iteration counter.
// No ports (package).
// -----------------------------------------------------------------------------
package linear_cordic_pkg;

   // Default datapath geometry. 1.0 is 1 << DEF_FRAC_BITS.
   localparam int DEF_BIT_WIDTH  = 27;
   localparam int DEF_FRAC_BITS  = 23;
   localparam int DEF_ITERATIONS = 24;

   // Controller state encoding, kept as plain 2-bit constants so older
   // checkers that compare against raw codes keep working.
   typedef logic [1:0] cordic_state_t;
   localparam cordic_state_t ST_IDLE = 2'd0;
   localparam cordic_state_t ST_RUN  = 2'd1;
   localparam cordic_state_t ST_DONE = 2'd2;

   // Iteration counter width: ceil(log2(iterations)), never below one bit.
   function automatic int cnt_width(input int iterations);
      return (iterations > 1) ? $clog2(iterations) : 1;
   endfunction

endpackage

// File: rtl/linear_cordic_rot_step.sv
// -----------------------------------------------------------------------------
// linear_cordic_rot_step
// One combinational linear-CORDIC rotation step. The sign of the residual
// angle z picks the direction: z is pushed toward zero by 2^(FRAC_BITS-shift)
// and y moves by (x >>> shift) in the matching direction. x is not touched,
// so it is not an output. All arithmetic wraps modulo 2^BIT_WIDTH.
//
// Ports
//   x      in   BIT_WIDTH  multiplicand (signed)
//   y      in   BIT_WIDTH  accumulator (signed)
//   z      in   BIT_WIDTH  residual angle (signed)
//   shift  in   SHIFT_W    step index, 0 .. FRAC_BITS
//   next_y out  BIT_WIDTH  accumulator after this step
//   next_z out  BIT_WIDTH  residual angle after this step
// -----------------------------------------------------------------------------
module linear_cordic_rot_step
   import linear_cordic_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int SHIFT_W   = 5
) (
   input  logic signed [BIT_WIDTH-1:0] x,
   input  logic signed [BIT_WIDTH-1:0] y,
   input  logic signed [BIT_WIDTH-1:0] z,
   input  logic        [SHIFT_W-1:0]   shift,
   output logic signed [BIT_WIDTH-1:0] next_y,
   output logic signed [BIT_WIDTH-1:0] next_z
);

   // 1.0 in the fixed-point format; the step angle is this shifted right,
   // which avoids a variable subtraction FRAC_BITS-shift in the datapath.
   localparam logic [BIT_WIDTH-1:0] ANGLE_BASE = BIT_WIDTH'(1) << FRAC_BITS;

   logic        [BIT_WIDTH-1:0] angle;
   logic signed [BIT_WIDTH-1:0] x_sh;
   logic                        z_neg;

   always_comb begin
      angle  = ANGLE_BASE >> shift;
      x_sh   = x >>> shift;
      z_neg  = z[BIT_WIDTH-1];
      next_y = y;
      next_z = z;
      if (z_neg) begin
         next_z = z + $signed(angle);
         next_y = y - x_sh;
      end else begin
         next_z = z - $signed(angle);
         next_y = y + x_sh;
      end
   end

endmodule

// File: rtl/linear_cordic_rot_iter.sv
// -----------------------------------------------------------------------------
// linear_cordic_rot_iter
// Iterative linear CORDIC in rotation mode: a multiply-accumulate
// y_out = y_in + x_in * z_in computed one rotation step per clock.
// A three-state controller (IDLE -> RUN -> DONE) sequences the steps; the
// register named "state" holds the controller state for probing.
//
// Handshake: an operand set transfers on a rising edge where in_valid and
// in_ready are both 1; a result transfers on a rising edge where out_valid and
// out_ready are both 1. in_ready is 1 only in IDLE and out_valid only in DONE,
// so accept and consume can never share an edge; in_valid seen outside IDLE is
// ignored, and outputs are held stable while out_valid waits for out_ready.
//
// Ports
//   clk        in   1          clock, rising edge
//   reset_n    in   1          asynchronous active-low reset
//   x_in       in   BIT_WIDTH  multiplicand
//   y_in       in   BIT_WIDTH  accumulator seed
//   z_in       in   BIT_WIDTH  multiplier (rotation angle)
//   in_valid   in   1          operand set valid
//   in_ready   out  1          block can accept operands (IDLE)
//   x_out      out  BIT_WIDTH  x passthrough
//   y_out      out  BIT_WIDTH  result y_in + x_in*z_in
//   z_out      out  BIT_WIDTH  residual angle, near zero after convergence
//   out_valid  out  1          result valid (DONE)
//   out_ready  in   1          consumer accepts the result
// -----------------------------------------------------------------------------
module linear_cordic_rot_iter
   import linear_cordic_pkg::*;
#(
   parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int ITERATIONS = DEF_ITERATIONS
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [BIT_WIDTH-1:0] x_in,
   input  logic [BIT_WIDTH-1:0] y_in,
   input  logic [BIT_WIDTH-1:0] z_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BIT_WIDTH-1:0] x_out,
   output logic [BIT_WIDTH-1:0] y_out,
   output logic [BIT_WIDTH-1:0] z_out,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int               CNT_W     = cnt_width(ITERATIONS);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

   cordic_state_t               state;
   logic        [CNT_W-1:0]     iter;
   logic signed [BIT_WIDTH-1:0] x_r;
   logic signed [BIT_WIDTH-1:0] y_r;
   logic signed [BIT_WIDTH-1:0] z_r;
   logic signed [BIT_WIDTH-1:0] step_y;
   logic signed [BIT_WIDTH-1:0] step_z;

   // Single shared step; the counter doubles as the shift amount.
   linear_cordic_rot_step #(
      .BIT_WIDTH (BIT_WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .SHIFT_W   (CNT_W)
   ) u_step (
      .x      (x_r),
      .y      (y_r),
      .z      (z_r),
      .shift  (iter),
      .next_y (step_y),
      .next_z (step_z)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         iter  <= '0;
         x_r   <= '0;
         y_r   <= '0;
         z_r   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  x_r   <= $signed(x_in);
                  y_r   <= $signed(y_in);
                  z_r   <= $signed(z_in);
                  iter  <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               y_r <= step_y;
               z_r <= step_z;
               // The step with the last shift is applied on the same edge
               // that moves to DONE, so the count stays at LAST_ITER there.
               if (iter == LAST_ITER) begin
                  state <= ST_DONE;
               end else begin
                  iter <= iter + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   // Results come straight from the working registers; they only change in
   // IDLE (load) and RUN (steps), so they are frozen throughout DONE.
   assign x_out = x_r;
   assign y_out = y_r;
   assign z_out = z_r;

endmodule

// File: tb/tb_linear_cordic_rot_iter.sv
// -----------------------------------------------------------------------------
// tb_linear_cordic_rot_iter
// Self-checking bench for linear_cordic_rot_iter: clock/reset, driver tasks,
// a reference model of the rotation recurrence on plain integers, an expected
// queue per output, a compare process on every falling edge, and a summary.
// -----------------------------------------------------------------------------
module tb_linear_cordic_rot_iter;

   localparam int W    = 27;
   localparam int FRAC = 23;
   localparam int ITER = 24;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] x_in, y_in, z_in;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x_out, y_out, z_out;
   logic         out_valid;
   logic         out_ready;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc = -1;
   int done_cnt = 0;
   bit b2b = 0;
   bit rand_ready = 0;
   bit prev_ov = 0;
   longint last_y = 0;
   longint last_z = 0;

   logic [W-1:0] exp_x_q[$];
   logic [W-1:0] exp_y_q[$];
   logic [W-1:0] exp_z_q[$];
   int           acc_q[$];

   linear_cordic_rot_iter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .x_in      (x_in),
      .y_in      (y_in),
      .z_in      (z_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_out     (x_out),
      .y_out     (y_out),
      .z_out     (z_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_tol(input string name, input longint act, input longint exp, input longint tol);
      longint d;
      checks++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   function automatic longint sx(input logic [W-1:0] v);
      longint r;
      r = longint'(v);
      if (v[W-1]) r = r - (longint'(1) <<< W);
      return r;
   endfunction

   // Reference: the rotation recurrence on integers, wrapped to W bits.
   function automatic void model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                 input logic [W-1:0] zv,
                                 output logic [W-1:0] yo, output logic [W-1:0] zo);
      longint x, y, z, d, a;
      x = sx(xv);
      y = sx(yv);
      z = sx(zv);
      for (int k = 0; k < ITER; k++) begin
         d = x >>> k;
         a = longint'(1) <<< (FRAC - k);
         if (z < 0) begin
            z = z + a;
            y = y - d;
         end else begin
            z = z - a;
            y = y + d;
         end
         z = sx(W'(z));
         y = sx(W'(y));
      end
      yo = W'(y);
      zo = W'(z);
   endfunction

   task automatic flush();
      exp_x_q.delete();
      exp_y_q.delete();
      exp_z_q.delete();
      acc_q.delete();
      prev_ov = 0;
      last_acc = -1;
   endtask

   // ---------------- driver ----------------
   // Waits for in_ready, presents the operands and leaves in_valid high.
   task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [W-1:0] zv);
      int n;
      int acc;
      logic [W-1:0] ey, ez;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("send_timeout", 64'(in_ready), 64'(1));
         return;
      end
      x_in = xv;
      y_in = yv;
      z_in = zv;
      in_valid = 1'b1;
      acc = cyc + 1;
      if (b2b && last_acc >= 0) check("accept_spacing", 64'(acc - last_acc), 64'(ITER + 2));
      last_acc = acc;
      model(xv, yv, zv, ey, ez);
      @(posedge clk);
      exp_x_q.push_back(xv);
      exp_y_q.push_back(ey);
      exp_z_q.push_back(ez);
      acc_q.push_back(acc);
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (exp_y_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_y_q.size() != 0) check(name, 64'(exp_y_q.size()), 64'(0));
      @(negedge clk);
   endtask

   task automatic run_one(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [W-1:0] zv);
      send(xv, yv, zv);
      #1 in_valid = 1'b0;
      wait_empty("result_timeout");
   endtask

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      if (reset_n) begin
         check("in_ready", 64'(in_ready), 64'(exp_y_q.size() == 0));
         if (out_valid) begin
            if (exp_y_q.size() == 0) begin
               check("spurious_out_valid", 64'(out_valid), 64'(0));
            end else begin
               if (!prev_ov) check("latency", 64'(cyc - acc_q[0]), 64'(ITER));
               check("x_out", 64'(x_out), 64'(exp_x_q[0]));
               check("y_out", 64'(y_out), 64'(exp_y_q[0]));
               check("z_out", 64'(z_out), 64'(exp_z_q[0]));
               if (out_ready) begin
                  last_y = sx(y_out);
                  last_z = sx(z_out);
                  void'(exp_x_q.pop_front());
                  void'(exp_y_q.pop_front());
                  void'(exp_z_q.pop_front());
                  void'(acc_q.pop_front());
                  done_cnt++;
               end
            end
         end
         prev_ov = out_valid;
      end
   end

   // Random back-pressure, changed away from both sampling edges.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [W-1:0] my, mz, rx, ry, rz;
      int seen;

      reset_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      x_in = '0;
      y_in = '0;
      z_in = '0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_y_out", 64'(y_out), 64'(0));
      check("rst_z_out", 64'(z_out), 64'(0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 reset_n = 1'b1;

      // Hand-derived pins on the reference model itself.
      model(27'h0C00000, 27'h0, 27'h0400000, my, mz);
      check("model_036_y", 64'(my), 64'(27'h0600002));
      check("model_036_z", 64'(mz), 64'(27'h7FFFFFF));
      model(27'h7800000, 27'h0, 27'h0200000, my, mz);
      check("model_037_y", 64'(my), 64'(27'h7DFFFFF));
      model(27'h0800000, 27'h0400000, 27'h7C00000, my, mz);
      check("model_038_y", 64'(my), 64'(27'h0000001));

      // Directed multiply-accumulate cases against literal answers.
      run_one(27'h0C00000, 27'h0, 27'h0400000);
      check_tol("req036_y", last_y, 64'sh0600000, 2);
      check_tol("req036_z", last_z, 0, 1);
      run_one(27'h7800000, 27'h0, 27'h0200000);
      check_tol("req037_y", last_y, -64'sh0200000, 2);
      run_one(27'h0800000, 27'h0400000, 27'h7C00000);
      check_tol("req038_y", last_y, 0, 2);

      // Out-of-range angles: wrapped but defined, same latency.
      run_one(27'h0800000, 27'h0, 27'h3000000);
      run_one(27'h0400000, 27'h0100000, 27'h4800000);

      // Hold in DONE with out_ready low; in_valid pulses must be ignored.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(27'h0A00000, 27'h7F00000, 27'h0300000);
      #1 in_valid = 1'b0;
      seen = 0;
      while (!out_valid && seen < 60) begin
         @(negedge clk);
         seen++;
      end
      check("hold_reached_done", 64'(out_valid), 64'(1));
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         in_valid = k[0];
         x_in = W'($urandom);
         z_in = W'($urandom);
         check("hold_out_valid", 64'(out_valid), 64'(1));
         check("hold_in_ready", 64'(in_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_out_valid", 64'(out_valid), 64'(0));
      check("release_in_ready", 64'(in_ready), 64'(1));
      wait_empty("hold_drain");

      // Reset during iteration 10 aborts the operation.
      send(27'h0C00000, 27'h0, 27'h0400000);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      flush();
      #1;
      check("midrun_rst_out_valid", 64'(out_valid), 64'(0));
      check("midrun_rst_in_ready", 64'(in_ready), 64'(1));
      check("midrun_rst_x_out", 64'(x_out), 64'(0));
      check("midrun_rst_y_out", 64'(y_out), 64'(0));
      check("midrun_rst_z_out", 64'(z_out), 64'(0));
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      #1 check("post_rst_in_ready", 64'(in_ready), 64'(1));
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_stale_result", 64'(seen), 64'(0));

      // Back-to-back with in_valid held high and out_ready=1.
      b2b = 1;
      for (int k = 0; k < 6; k++) begin
         rx = W'(int'($urandom_range(0, 32'h0FFFFFF)) - 32'sh0800000);
         ry = W'(int'($urandom_range(0, 32'h0FFFFFF)) - 32'sh0800000);
         rz = W'(int'($urandom_range(0, 32'h1FFFFFC)) - 32'sh0FFFFFE);
         send(rx, ry, rz);
      end
      #1 in_valid = 1'b0;
      b2b = 0;
      wait_empty("b2b_drain");

      // Random operands with random back-pressure.
      rand_ready = 1;
      for (int k = 0; k < 20; k++) begin
         rx = W'(int'($urandom_range(0, 32'h0FFFFFF)) - 32'sh0800000);
         ry = W'(int'($urandom_range(0, 32'h0FFFFFF)) - 32'sh0800000);
         rz = W'(int'($urandom_range(0, 32'h1FFFFFC)) - 32'sh0FFFFFE);
         model(rx, ry, rz, my, mz);
         check_tol("model_vs_ideal", sx(my), sx(ry) + ((sx(rx) * sx(rz)) >>> FRAC), 32);
         send(rx, ry, rz);
         #1 in_valid = 1'b0;
      end
      rand_ready = 0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      wait_empty("random_drain");

      check("results_consumed", 64'(done_cnt), 64'(5 + 1 + 6 + 20));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
